// File: rtl/spi_reg_ctrl.sv
// SPI transaction framer and 2^ADDR_W x 8 register file driving the 7-segment display.
// Build option SPI_REG_AUTOINC_EN: advance the register address after every data byte.
//
// state | meaning
// IDLE  | no open chip-select window; rx_dv ignored
// CMD   | ID byte issued, waiting for the command byte
// WRITE | each received byte is written to reg[addr]
// READ  | each received (dummy) byte returns reg[addr] on MISO
module spi_reg_ctrl #(
  parameter int         ADDR_W    = 3,
  parameter logic [7:0] ID_BYTE   = 8'hA5,
  parameter logic [1:0] COLON_RST = 2'b11
) (
  input  logic       WF_CLK,
  input  logic       WF_RST,
  input  logic       cs_n,
  input  logic       rx_dv,
  input  logic [7:0] rx_byte,
  output logic       tx_dv,
  output logic [7:0] tx_byte,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [1:0] colon,
  output logic       busy
);

  localparam int NREG = 1 << ADDR_W;
`ifdef SPI_REG_AUTOINC_EN
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(1);
`else
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(0);
`endif

  typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;

  state_t            state_q, state_d;
  logic [7:0]        regs [NREG];
  logic [ADDR_W-1:0] addr_q, acc_addr;
  logic              cs_s1, cs_s2, cs_d, cs_armed;
  logic [1:0]        sync_vld;
  logic              cs_fall, cs_rise;
  logic              load_id, cmd_take, wr_en, rd_en;
  logic              unused_cmd_bits;

  // A window already open when reset releases must not start a transaction:
  // falls only count once a genuine high level has been seen after reset.
  always_ff @(posedge WF_CLK) begin
    if (WF_RST) begin
      cs_s1    <= 1'b1;
      cs_s2    <= 1'b1;
      cs_d     <= 1'b1;
      sync_vld <= 2'b00;
      cs_armed <= 1'b0;
    end else begin
      cs_s1    <= cs_n;
      cs_s2    <= cs_s1;
      cs_d     <= cs_s2;
      sync_vld <= {sync_vld[0], 1'b1};
      if (sync_vld[1] && cs_s2) cs_armed <= 1'b1;
    end
  end

  assign cs_fall = cs_armed & cs_d & ~cs_s2;
  assign cs_rise = ~cs_d & cs_s2;

  always_ff @(posedge WF_CLK) begin
    if (WF_RST) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load_id  = 1'b0;
    cmd_take = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    if (cs_fall) begin
      state_d = CMD;
      load_id = 1'b1;
    end else begin
      case (state_q)
        CMD: begin
          if (rx_dv) begin
            cmd_take = 1'b1;
            rd_en    = rx_byte[7];
            state_d  = rx_byte[7] ? READ : WRITE;
          end
        end
        WRITE:   wr_en = rx_dv;
        READ:    rd_en = rx_dv;
        default: ;
      endcase
      // The byte in flight is still processed before the window closes.
      if (cs_rise && state_q != IDLE) state_d = IDLE;
    end
  end

  assign acc_addr        = cmd_take ? rx_byte[ADDR_W-1:0] : addr_q;
  assign unused_cmd_bits = ^rx_byte[6:ADDR_W];

  always_ff @(posedge WF_CLK) begin
    if (WF_RST) begin
      tx_dv   <= 1'b0;
      tx_byte <= 8'h00;
      addr_q  <= '0;
      for (int i = 0; i < NREG; i++)
        regs[i] <= (i == 2) ? {6'b0, COLON_RST} : 8'h00;
    end else begin
      tx_dv <= load_id | rd_en;
      if (load_id)    tx_byte <= ID_BYTE;
      else if (rd_en) tx_byte <= regs[acc_addr];
      if (rd_en || wr_en) addr_q <= acc_addr + ADDR_STEP;
      else if (cmd_take)  addr_q <= acc_addr;
      if (wr_en) regs[acc_addr] <= rx_byte;
    end
  end

  assign digit0 = regs[0][3:0];
  assign digit1 = regs[0][7:4];
  assign digit2 = regs[1][3:0];
  assign digit3 = regs[1][7:4];
  assign colon  = regs[2][1:0];
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Randomized bench for spi_reg_ctrl: transaction-level reference model compared
// against the DUT every cycle, plus hand-computed literal expectations.
module tb_spi_reg_ctrl;

  logic       WF_CLK = 1'b0;
  logic       WF_RST = 1'b1;
  logic       cs_n = 1'b1;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic [1:0] colon;
  logic       busy;

`ifdef SPI_REG_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif
  localparam int STEP = AUTOINC ? 1 : 0;

  int errors = 0;
  int checks = 0;
  bit cmp_on = 1'b0;

  spi_reg_ctrl dut (
    .WF_CLK(WF_CLK), .WF_RST(WF_RST), .cs_n(cs_n), .rx_dv(rx_dv), .rx_byte(rx_byte),
    .tx_dv(tx_dv), .tx_byte(tx_byte), .digit0(digit0), .digit1(digit1),
    .digit2(digit2), .digit3(digit3), .colon(colon), .busy(busy)
  );

  always #5 WF_CLK = ~WF_CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a chip-select window is a byte stream; byte 0 is the
  // command, the rest are data. Pin samples pass through a 3-deep history
  // (two sync stages plus the edge stage); history starts low after reset so
  // a window already open at reset release is never seen as a new one.
  bit [7:0] mem [8];
  bit       open_m, have_cmd, rd_m, h1, h2, h3, fall_m, rise_m;
  int       ptr;
  bit       m_tx_dv;
  bit [7:0] m_tx_byte;

  always @(posedge WF_CLK) begin
    if (WF_RST) begin
      for (int i = 0; i < 8; i++) mem[i] = 8'h00;
      mem[2] = 8'h03;
      m_tx_dv = 0; m_tx_byte = 8'h00;
      open_m = 0; have_cmd = 0; rd_m = 0; ptr = 0;
      h1 = 0; h2 = 0; h3 = 0;
    end else begin
      fall_m = h3 & ~h2;
      rise_m = ~h3 & h2;
      h3 = h2; h2 = h1; h1 = cs_n;
      m_tx_dv = 0;
      if (fall_m) begin
        open_m = 1; have_cmd = 0;
        m_tx_byte = 8'hA5; m_tx_dv = 1;
      end else if (open_m) begin
        if (rx_dv) begin
          if (!have_cmd) begin
            have_cmd = 1;
            rd_m = rx_byte[7];
            ptr = int'(rx_byte[2:0]);
            if (rd_m) begin
              m_tx_byte = mem[ptr]; m_tx_dv = 1; ptr = (ptr + STEP) % 8;
            end
          end else if (rd_m) begin
            m_tx_byte = mem[ptr]; m_tx_dv = 1; ptr = (ptr + STEP) % 8;
          end else begin
            mem[ptr] = rx_byte; ptr = (ptr + STEP) % 8;
          end
        end
        if (rise_m) open_m = 0;
      end
    end
  end

  always @(negedge WF_CLK) begin
    if (cmp_on) begin
      chk("cyc_tx_dv", 32'(tx_dv), 32'(m_tx_dv));
      chk("cyc_tx_byte", 32'(tx_byte), 32'(m_tx_byte));
      chk("cyc_busy", 32'(busy), 32'(open_m));
      chk("cyc_digits", 32'({digit3, digit2, digit1, digit0}), 32'({mem[1], mem[0]}));
      chk("cyc_colon", 32'(colon), 32'(mem[2][1:0]));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge WF_CLK);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte = b;
    rx_dv   = 1'b1;
    tick(1);
    rx_dv   = 1'b0;
    rx_byte = 8'($urandom);
  endtask

  task automatic cs_start();
    cs_n = 1'b0;
    tick(4);
  endtask

  task automatic cs_end();
    cs_n = 1'b1;
    tick(4);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tick(1);
    cmp_on = 1'b1;
    chk("rst_digits", 32'({digit3, digit2, digit1, digit0}), 32'h0000);
    chk("rst_colon", 32'(colon), 32'h3);
    chk("rst_tx_dv", 32'(tx_dv), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    tick(2);
    WF_RST = 1'b0;
    tick(4);

    // ID byte latency and first write burst (back-to-back rx_dv)
    cs_n = 1'b0;
    tick(2);
    chk("id_early", 32'(tx_dv), 32'h0);
    tick(1);
    chk("id_tx_dv", 32'(tx_dv), 32'h1);
    chk("id_byte", 32'(tx_byte), 32'hA5);
    chk("id_busy", 32'(busy), 32'h1);
    tick(1);
    chk("id_pulse_len", 32'(tx_dv), 32'h0);
    send(8'h00); send(8'h12); send(8'h34); send(8'h03);
    cs_end();
    chk("wr_digits", 32'({digit3, digit2, digit1, digit0}), AUTOINC ? 32'h3412 : 32'h0003);
    chk("wr_colon", 32'(colon), 32'h3);
    chk("wr_busy", 32'(busy), 32'h0);

    // Address wrap
    cs_start();
    send(8'h07); tick(1); send(8'hAA); send(8'hBB);
    cs_end();
    chk("wrap_digits", 32'({digit3, digit2, digit1, digit0}), AUTOINC ? 32'h34BB : 32'h0003);
    chk("model_reg7", 32'(mem[7]), AUTOINC ? 32'hAA : 32'hBB);
    cs_start();
    send(8'h87);
    chk("rd_reg7", 32'(tx_byte), AUTOINC ? 32'hAA : 32'hBB);
    cs_end();

    // Preload reg1/reg2, then read burst
    cs_start(); send(8'h01); send(8'h56); cs_end();
    cs_start(); send(8'h02); send(8'h01); cs_end();
    chk("pre_colon", 32'(colon), 32'h1);
    chk("pre_reg1", 32'({digit3, digit2}), 32'h56);
    cs_start();
    send(8'h81);
    chk("rd0_tx_dv", 32'(tx_dv), 32'h1);
    chk("rd0_byte", 32'(tx_byte), 32'h56);
    tick(1);
    chk("rd0_pulse_len", 32'(tx_dv), 32'h0);
    send(8'hFF);
    chk("rd1_byte", 32'(tx_byte), AUTOINC ? 32'h01 : 32'h56);
    send(8'h00);
    chk("rd2_byte", 32'(tx_byte), AUTOINC ? 32'h00 : 32'h56);
    cs_end();
    chk("rd_keep_reg1", 32'({digit3, digit2}), 32'h56);
    chk("rd_keep_colon", 32'(colon), 32'h1);

    // Last data byte coincides with the synchronized cs rise
    cs_start();
    send(8'h00);
    cs_n = 1'b1;
    tick(2);
    send(8'h99);
    chk("rise_commit", 32'({digit1, digit0}), 32'h99);
    chk("rise_idle", 32'(busy), 32'h0);
    tick(3);

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      int nb, sel;
      cs_start();
      nb = $urandom_range(0, 5);
      for (int b = 0; b < nb; b++) begin
        tick($urandom_range(0, 2));
        send(8'($urandom));
      end
      sel = $urandom_range(0, 3);
      if (sel == 0) begin
        cs_n = 1'b1;
        tick(1);
        cs_n = 1'b0;
        tick(4);
        send(8'($urandom));
        send(8'($urandom));
        cs_end();
      end else if (sel == 1) begin
        cs_n = 1'b1;
        tick(2);
        send(8'($urandom));
        tick(3);
      end else begin
        cs_end();
      end
    end

    // Reset mid-write with the window left open
    cs_start();
    send(8'h00); send(8'h77);
    chk("pre_rst_digits", 32'({digit1, digit0}), 32'h77);
    WF_RST = 1'b1;
    tick(1);
    WF_RST = 1'b0;
    chk("mid_rst_digits", 32'({digit3, digit2, digit1, digit0}), 32'h0000);
    chk("mid_rst_colon", 32'(colon), 32'h3);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_tx_byte", 32'(tx_byte), 32'h00);
    tick(3);
    send(8'h00); send(8'h44);
    tick(1);
    chk("stale_win_digits", 32'({digit3, digit2, digit1, digit0}), 32'h0000);
    chk("stale_win_busy", 32'(busy), 32'h0);
    cs_end();

    // Fresh window after reset works again
    cs_start();
    send(8'h00); send(8'h21);
    cs_end();
    chk("post_rst_write", 32'({digit1, digit0}), 32'h21);

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

Transaction controller between the SPI slave byte engine and the 7-segment display driver. It frames each chip-select window into a command byte followed by data bytes, and maintains an 8-entry × 8-bit register file. For reads, it feeds MISO bytes back to the byte engine. The register file directly drives the display digit and colon inputs.

## Interface
Parameters:
- ADDR_W, 3: register address width; register count is 2^ADDR_W.
- ID_BYTE, 8'hA5: byte preloaded for MISO at the start of every transaction.
- COLON_RST, 2'b11: reset value of reg2[1:0] (colon off).

Ports:
- WF_CLK  in  1  system clock; all logic on posedge.
- WF_RST  in  1  synchronous, active-high reset.
- cs_n  in  1  raw SPI chip select, active low, asynchronous to WF_CLK.
- rx_dv  in  1  one-cycle pulse: rx_byte is valid.
- rx_byte  in  8  byte received on MOSI.
- tx_dv  out  1  one-cycle pulse: byte engine registers tx_byte.
- tx_byte  out  8  next byte to shift on MISO.
- digit0, digit1, digit2, digit3  out  4 each  BCD digits; digit0 = reg0[3:0], digit1 = reg0[7:4], digit2 = reg1[3:0], digit3 = reg1[7:4].
- colon  out  2  reg2[1:0]; 00 colon, 01 decimal point, 11 none.
- busy  out  1  high while the state is not IDLE.

## Operation
- cs_n passes through a 2-flop synchronizer, then an edge detector: cs_fall and cs_rise are one-cycle pulses.
- FSM states: IDLE, CMD, WRITE, READ.
  - IDLE: on cs_fall, go to CMD. In the same cycle, load tx_byte = ID_BYTE and pulse tx_dv. rx_dv is ignored in IDLE.
  - CMD: on rx_dv, capture the command byte.
    - Bit 7 = 1 selects a read; 0 selects a write.
    - addr = rx_byte[ADDR_W-1:0]. Bits [6:ADDR_W] are ignored.
    - Next state is READ or WRITE.
    - For a read, on the cycle after the command rx_dv: tx_byte = reg[addr], tx_dv pulses, addr increments.
  - WRITE: each rx_dv writes reg[addr] = rx_byte, then addr increments.
  - READ: each rx_dv (dummy byte, value discarded) triggers tx_byte = reg[addr] with a tx_dv pulse one cycle later, then addr increments.
  - Any state except IDLE: cs_rise returns the FSM to IDLE.
- Address arithmetic is modulo 2^ADDR_W: 7 + 1 wraps to 0.
- Registers reg3..reg7 are general scratch with no side effects.
- tx_byte holds its last value between tx_dv pulses.

## Timing
- Reset values:
  - All registers 0x00, except reg2 = {6'b0, COLON_RST}.
  - digits 0; colon = COLON_RST; tx_dv 0; tx_byte 0x00; busy 0; state IDLE; addr 0.
  - Synchronizer flops reset to 1 (deasserted).
- cs_n falling pin edge to tx_dv: 3 WF_CLK cycles (two sync flops plus one edge register).
- Write: rx_dv in cycle N → register and display outputs update at the edge ending cycle N, visible in cycle N+1.
- Read: rx_dv in cycle N → tx_dv high in cycle N+1 only, and tx_byte is stable from N+1.
- rx_dv back-to-back on consecutive cycles: every byte is processed, with no drops.
- rx_dv and cs_rise in the same cycle: the byte is processed first (write commits, or read tx_dv is issued), then the FSM enters IDLE. A pending read tx_dv still fires in the following cycle.
- cs_fall while not in IDLE (glitch shorter than the sync delay): treated as a new transaction. Go to CMD and reissue ID_BYTE.
- WF_RST asserted mid-transaction: everything returns to reset values on the next edge, including the register file.
- A transaction that is still open after reset releases is ignored until a fresh cs_fall.

## Configuration
- SPI_REG_AUTOINC_EN defined: addr increments after every data byte, as described above.
- Not defined: addr stays fixed at the command address for the whole transaction. Repeated writes overwrite the same register; repeated reads return the same register.
- Both builds use identical FSM and timing.

## Test plan
- Reset → digits 0/0/0/0, colon 2'b11, tx_dv 0, busy 0.
- cs low → tx_dv with 0xA5 exactly 3 cycles later. Then send cmd 0x00 and data 0x12, 0x34, 0x03, then cs high → digit0 = 2, digit1 = 1, digit2 = 4, digit3 = 3, colon = 2'b11, busy 0.
- cmd 0x07, data 0xAA, 0xBB → with AUTOINC: reg7 = 0xAA, reg0 = 0xBB (wrap). Without AUTOINC: reg7 = 0xBB, reg0 unchanged.
- Preload reg1 = 0x56 and reg2 = 0x01. Send cmd 0x81, then two dummy bytes → tx_dv one cycle after each rx_dv, carrying 0x56, then 0x01, then reg3. Registers are not modified.
- Assert WF_RST during the WRITE state after one data byte → all registers back to reset. A later rx_dv without a new cs_fall writes nothing.
- Final data rx_dv in the same cycle as cs_rise → the write is committed and the FSM is in IDLE on the next cycle.
